// File: rtl/dmem_shadow_multi.sv
// Shadow data memory and handshake monitor for a native valid/ready memory bus; drives nothing onto the bus.
// Latency: hit/expect_* are combinational; shadow contents, sticky flags and stall_cnt update on the next edge.
// Backpressure: none exerted; wait states are counted and requests that change while stalled are flagged.
module dmem_shadow_multi #(
    parameter int XLEN     = 32,
    parameter int NWATCH   = 4,
    parameter int MAX_WAIT = 16,
    parameter int LEARN    = 1,
    localparam int NB  = XLEN / 8,
    localparam int LSB = $clog2(NB),
    localparam int IW  = (NWATCH > 1) ? $clog2(NWATCH) : 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   mem_valid,
    input  logic                   mem_instr,
    input  logic                   mem_ready,
    input  logic [XLEN-1:0]        mem_addr,
    input  logic [XLEN-1:0]        mem_wdata,
    input  logic [NB-1:0]          mem_wstrb,
    input  logic [XLEN-1:0]        mem_rdata,
    input  logic [NWATCH*XLEN-1:0] watch_addr,
    output logic                   hit,
    output logic [IW-1:0]          hit_idx,
    output logic [XLEN-1:0]        expect_rdata,
    output logic [NB-1:0]          expect_mask,
    output logic                   mismatch,
    output logic [IW-1:0]          mismatch_idx,
    output logic                   proto_err,
    output logic                   stall_err,
    output logic [7:0]             stall_cnt
);

    logic            xfer, stall, match_any, rd_mis;
    logic [IW-1:0]   match_idx;
    logic [XLEN-1:0] eff_data [NWATCH];
    logic [NB-1:0]   eff_valid[NWATCH];

    logic [XLEN-1:0] watch_q[NWATCH], watch_d[NWATCH];
    logic [XLEN-1:0] data_q [NWATCH], data_d [NWATCH];
    logic [NB-1:0]   valid_q[NWATCH], valid_d[NWATCH];
    logic            pend_q, pend_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d, req_wdata_q, req_wdata_d;
    logic [NB-1:0]   req_wstrb_q, req_wstrb_d;
    logic            req_instr_q, req_instr_d;
    logic [7:0]      stall_cnt_q, stall_cnt_d;
    logic            mismatch_q, mismatch_d, proto_err_q, proto_err_d, stall_err_q, stall_err_d;
    logic [IW-1:0]   mismatch_idx_q, mismatch_idx_d;

    assign xfer  = mem_valid && mem_ready;
    assign stall = mem_valid && !mem_ready;

    // Descending scan so the lowest matching entry is the one left standing.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int k = NWATCH - 1; k >= 0; k--) begin
            if (mem_addr[XLEN-1:LSB] == watch_addr[k*XLEN+LSB +: XLEN-LSB]) begin
                match_any = 1'b1;
                match_idx = IW'(k);
            end
        end
    end

    // An entry whose watch address moved this cycle is treated as already cleared.
    always_comb begin
        for (int k = 0; k < NWATCH; k++) begin
            if (watch_addr[k*XLEN +: XLEN] != watch_q[k]) begin
                eff_data[k]  = '0;
                eff_valid[k] = '0;
            end else begin
                eff_data[k]  = data_q[k];
                eff_valid[k] = valid_q[k];
            end
        end
    end

    assign hit     = xfer && match_any;
    assign hit_idx = hit ? match_idx : '0;

    always_comb begin
        expect_rdata = '0;
        expect_mask  = '0;
        for (int k = 0; k < NWATCH; k++) begin
            if (hit && hit_idx == IW'(k)) begin
                expect_rdata = eff_data[k];
                expect_mask  = eff_valid[k];
            end
        end
    end

    always_comb begin
        rd_mis         = 1'b0;
        mismatch_d     = mismatch_q;
        mismatch_idx_d = mismatch_idx_q;
        for (int k = 0; k < NWATCH; k++) begin
            watch_d[k] = watch_addr[k*XLEN +: XLEN];
            data_d[k]  = eff_data[k];
            valid_d[k] = eff_valid[k];
            if (hit && hit_idx == IW'(k)) begin
                for (int i = 0; i < NB; i++) begin
                    if (mem_wstrb != '0) begin
                        if (mem_wstrb[i]) begin
                            data_d[k][8*i +: 8] = mem_wdata[8*i +: 8];
                            valid_d[k][i]       = 1'b1;
                        end
                    end else if (eff_valid[k][i]) begin
                        if (mem_rdata[8*i +: 8] != eff_data[k][8*i +: 8]) begin
                            rd_mis = 1'b1;
                        end
                    end else if (LEARN != 0) begin
                        data_d[k][8*i +: 8] = mem_rdata[8*i +: 8];
                        valid_d[k][i]       = 1'b1;
                    end
                end
            end
        end
        if (rd_mis) begin
            mismatch_d = 1'b1;
            if (!mismatch_q) begin
                mismatch_idx_d = hit_idx;
            end
        end
    end

    always_comb begin
        pend_d      = stall;
        req_addr_d  = stall ? mem_addr  : req_addr_q;
        req_wdata_d = stall ? mem_wdata : req_wdata_q;
        req_wstrb_d = stall ? mem_wstrb : req_wstrb_q;
        req_instr_d = stall ? mem_instr : req_instr_q;
        proto_err_d = proto_err_q;
        if (pend_q && (!mem_valid || mem_addr != req_addr_q || mem_wdata != req_wdata_q ||
                       mem_wstrb != req_wstrb_q || mem_instr != req_instr_q)) begin
            proto_err_d = 1'b1;
        end
        stall_cnt_d = '0;
        if (stall) begin
            stall_cnt_d = (stall_cnt_q == 8'hFF) ? 8'hFF : stall_cnt_q + 8'd1;
        end
        stall_err_d = stall_err_q || (stall && stall_cnt_q == 8'(MAX_WAIT));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < NWATCH; k++) begin
                watch_q[k] <= '0;
                data_q[k]  <= '0;
                valid_q[k] <= '0;
            end
            pend_q         <= 1'b0;
            req_addr_q     <= '0;
            req_wdata_q    <= '0;
            req_wstrb_q    <= '0;
            req_instr_q    <= 1'b0;
            stall_cnt_q    <= '0;
            mismatch_q     <= 1'b0;
            mismatch_idx_q <= '0;
            proto_err_q    <= 1'b0;
            stall_err_q    <= 1'b0;
        end else begin
            for (int k = 0; k < NWATCH; k++) begin
                watch_q[k] <= watch_d[k];
                data_q[k]  <= data_d[k];
                valid_q[k] <= valid_d[k];
            end
            pend_q         <= pend_d;
            req_addr_q     <= req_addr_d;
            req_wdata_q    <= req_wdata_d;
            req_wstrb_q    <= req_wstrb_d;
            req_instr_q    <= req_instr_d;
            stall_cnt_q    <= stall_cnt_d;
            mismatch_q     <= mismatch_d;
            mismatch_idx_q <= mismatch_idx_d;
            proto_err_q    <= proto_err_d;
            stall_err_q    <= stall_err_d;
        end
    end

    assign mismatch     = mismatch_q;
    assign mismatch_idx = mismatch_idx_q;
    assign proto_err    = proto_err_q;
    assign stall_err    = stall_err_q;
    assign stall_cnt    = stall_cnt_q;

endmodule
